// File: rtl/drum_machine_top.sv
// rtl/drum_machine_top.sv - 8-step x 8-track drum sequencer with button debounce and 4-digit display
module drum_machine_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          armed;
    logic [CW-1:0] cnt;

    // Fires on the sample that completes DB_CYCLES consecutive highs.
    assign pulse = armed & sync2 & (cnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            armed <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (!sync2) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else if (pulse) begin
                cnt   <= '0;
                armed <= 1'b0;
            end else if (armed) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module drum_machine_top #(
    parameter int STEP_DIV  = 12500000,
    parameter int DB_CYCLES = 500000,
    parameter int SCAN_BITS = 18
) (
    input  logic ClkPort,
    input  logic ResetN,
    input  logic BtnC,
    input  logic BtnU,
    input  logic BtnD,
    input  logic BtnL,
    input  logic BtnR,
    input  logic Sw7, Sw6, Sw5, Sw4, Sw3, Sw2, Sw1, Sw0,
    output logic Ld7, Ld6, Ld5, Ld4, Ld3, Ld2, Ld1, Ld0,
    output logic An3, An2, An1, An0,
    output logic Ca, Cb, Cc, Cd, Ce, Cf, Cg, Dp,
    output logic MemOE,
    output logic MemWR,
    output logic RamCS,
    output logic FlashCS,
    output logic QuadSpiFlashCS
);
    localparam int TW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_EDIT} state_t;

    state_t               state;
    logic [2:0]           step;
    logic [7:0]           pattern [8];
    logic [TW-1:0]        tick;
    logic [SCAN_BITS-1:0] scan;
    logic [4:0]           btn;
    logic [4:0]           pulse;
    logic [4:0]           act;
    logic [7:0]           sw;
    logic [7:0]           led;
    logic [1:0]           sel;
    logic [6:0]           seg;

    assign btn = {BtnR, BtnL, BtnD, BtnU, BtnC};
    assign sw  = {Sw7, Sw6, Sw5, Sw4, Sw3, Sw2, Sw1, Sw0};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        drum_machine_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk   (ClkPort),
            .rst_n (ResetN),
            .btn   (btn[i]),
            .pulse (pulse[i])
        );
    end

    // Keep only the highest-priority pulse: C > U > D > L > R.
    always_comb begin
        act = 5'b00000;
        if      (pulse[0]) act[0] = 1'b1;
        else if (pulse[1]) act[1] = 1'b1;
        else if (pulse[2]) act[2] = 1'b1;
        else if (pulse[3]) act[3] = 1'b1;
        else if (pulse[4]) act[4] = 1'b1;
    end

    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) begin
            state <= ST_STOP;
            step  <= 3'd0;
            tick  <= '0;
            for (int i = 0; i < 8; i++) pattern[i] <= 8'h00;
        end else begin
            case (state)
                ST_STOP: begin
                    if (act[0]) begin
                        state <= ST_PLAY;
                        tick  <= '0;
                    end else if (act[1]) begin
                        state <= ST_EDIT;
                    end else if (act[2]) begin
                        for (int i = 0; i < 8; i++) pattern[i] <= 8'h00;
                    end
                end
                ST_PLAY: begin
                    if (act[0]) begin
                        state <= ST_STOP;
                    end else if (act[1]) begin
                        state <= ST_EDIT;
                    end else if (tick == TW'(STEP_DIV - 1)) begin
                        tick <= '0;
                        step <= step + 3'd1;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                ST_EDIT: begin
                    if (act[1])      state <= ST_STOP;
                    else if (act[3]) step <= step - 3'd1;
                    else if (act[4]) step <= step + 3'd1;
                    else if (act[2]) pattern[step] <= sw;
                end
                default: state <= ST_STOP;
            endcase
        end
    end

    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) scan <= '0;
        else         scan <= scan + SCAN_BITS'(1);
    end

    assign led = pattern[step];
    assign {Ld7, Ld6, Ld5, Ld4, Ld3, Ld2, Ld1, Ld0} = led;
    assign sel = scan[SCAN_BITS-1 -: 2];

    // seg is active-high {a,b,c,d,e,f,g}; digits 1 and 2 stay blank.
    always_comb begin
        seg = 7'b0000000;
        if (sel == 2'd0) begin
            case (step)
                3'd0: seg = 7'b1111110;
                3'd1: seg = 7'b0110000;
                3'd2: seg = 7'b1101101;
                3'd3: seg = 7'b1111001;
                3'd4: seg = 7'b0110011;
                3'd5: seg = 7'b1011011;
                3'd6: seg = 7'b1011111;
                default: seg = 7'b1110000;
            endcase
        end else if (sel == 2'd3) begin
            case (state)
                ST_PLAY: seg = 7'b1100111;
                ST_EDIT: seg = 7'b1001111;
                default: seg = 7'b1011011;
            endcase
        end
    end

    assign {Ca, Cb, Cc, Cd, Ce, Cf, Cg} = ~seg;
    assign Dp = 1'b1;
    assign {An3, An2, An1, An0} = ~(4'b0001 << sel);

    assign MemOE          = 1'b1;
    assign MemWR          = 1'b1;
    assign RamCS          = 1'b1;
    assign FlashCS        = 1'b1;
    assign QuadSpiFlashCS = 1'b1;
endmodule

// File: tb/tb_drum_machine_top.sv
// tb/tb_drum_machine_top.sv - randomized + directed bench for drum_machine_top against a behavioural model
module tb_drum_machine_top;
    localparam int STEP_DIV = 4;
    localparam int DB       = 2;
    localparam int SB       = 4;
    localparam int S_STOP = 0, S_PLAY = 1, S_EDIT = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] btn   = 5'b0;
    logic [7:0] sw    = 8'h00;
    logic       cmp_en = 1'b0;

    always #5 clk = ~clk;

    wire [7:0] ld;
    wire [3:0] an;
    wire ca, cb, cc, cd, ce, cf, cg, dp;
    wire mem_oe, mem_wr, ram_cs, flash_cs, qspi_cs;

    drum_machine_top #(.STEP_DIV(STEP_DIV), .DB_CYCLES(DB), .SCAN_BITS(SB)) dut (
        .ClkPort(clk), .ResetN(rst_n),
        .BtnC(btn[0]), .BtnU(btn[1]), .BtnD(btn[2]), .BtnL(btn[3]), .BtnR(btn[4]),
        .Sw7(sw[7]), .Sw6(sw[6]), .Sw5(sw[5]), .Sw4(sw[4]),
        .Sw3(sw[3]), .Sw2(sw[2]), .Sw1(sw[1]), .Sw0(sw[0]),
        .Ld7(ld[7]), .Ld6(ld[6]), .Ld5(ld[5]), .Ld4(ld[4]),
        .Ld3(ld[3]), .Ld2(ld[2]), .Ld1(ld[1]), .Ld0(ld[0]),
        .An3(an[3]), .An2(an[2]), .An1(an[1]), .An0(an[0]),
        .Ca(ca), .Cb(cb), .Cc(cc), .Cd(cd), .Ce(ce), .Cf(cf), .Cg(cg), .Dp(dp),
        .MemOE(mem_oe), .MemWR(mem_wr), .RamCS(ram_cs), .FlashCS(flash_cs),
        .QuadSpiFlashCS(qspi_cs)
    );

    wire [6:0]  seg_n   = {ca, cb, cc, cd, ce, cf, cg};
    wire [4:0]  mem_all = {mem_oe, mem_wr, ram_cs, flash_cs, qspi_cs};
    wire [24:0] dut_vec = {ld, an, seg_n, dp, mem_all};

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int         m_state;
    int         m_step;
    logic [7:0] m_pat [8];
    int         m_tick;
    int         m_cyc;
    logic       h1 [5];
    logic       h2 [5];
    int         run [5];

    string digit_seg [8] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc"};
    string mode_seg  [3] = '{"acdfg", "abefg", "adefg"};

    function automatic logic [6:0] mask(input string s);
        logic [6:0] m = 7'b0;
        for (int i = 0; i < s.len(); i++) begin
            int k = int'(s[i]) - 97;
            m[6 - k] = 1'b1;
        end
        return m;
    endfunction

    function automatic void model_reset();
        m_state = S_STOP;
        m_step  = 0;
        m_tick  = 0;
        m_cyc   = 0;
        for (int i = 0; i < 8; i++) m_pat[i] = 8'h00;
        for (int b = 0; b < 5; b++) begin
            h1[b] = 1'b0; h2[b] = 1'b0; run[b] = 0;
        end
    endfunction

    function automatic void model_clock();
        int win = -1;
        // A button acts on the clock where its level, seen two clocks late,
        // completes exactly DB consecutive high samples.
        for (int b = 0; b < 5; b++) begin
            if (h2[b]) begin
                if (run[b] <= DB) run[b]++;
            end else begin
                run[b] = 0;
            end
            if (h2[b] && run[b] == DB && win < 0) win = b;
            h2[b] = h1[b];
            h1[b] = btn[b];
        end
        case (m_state)
            S_STOP: begin
                if (win == 0) begin m_state = S_PLAY; m_tick = 0; end
                else if (win == 1) m_state = S_EDIT;
                else if (win == 2) for (int i = 0; i < 8; i++) m_pat[i] = 8'h00;
            end
            S_PLAY: begin
                if (win == 0) m_state = S_STOP;
                else if (win == 1) m_state = S_EDIT;
                else begin
                    m_tick++;
                    if (m_tick == STEP_DIV) begin
                        m_tick = 0;
                        m_step = (m_step + 1) % 8;
                    end
                end
            end
            default: begin
                if (win == 1) m_state = S_STOP;
                else if (win == 3) m_step = (m_step + 7) % 8;
                else if (win == 4) m_step = (m_step + 1) % 8;
                else if (win == 2) m_pat[m_step] = sw;
            end
        endcase
        m_cyc = (m_cyc + 1) % (1 << SB);
    endfunction

    function automatic logic [24:0] exp_vec();
        int         sel = m_cyc >> (SB - 2);
        logic [6:0] s   = 7'b0;
        logic [3:0] oh  = 4'b0001 << sel;
        if (sel == 0)      s = mask(digit_seg[m_step]);
        else if (sel == 3) s = mask(mode_seg[m_state]);
        return {m_pat[m_step], ~oh, ~s, 1'b1, 5'b11111};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_clock();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [24:0] e;
            e = exp_vec();
            tests++;
            if (dut_vec !== e) begin
                fails++;
                $display("FAIL outputs t=%0t dut=%h model=%h", $time, dut_vec, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input int b);
        btn[b] = 1'b1;
        repeat (4) step();
        btn[b] = 1'b0;
        repeat (4) step();
    endtask

    task automatic wait_sel(input int n);
        logic [3:0] want = ~(4'b0001 << n);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (an === want) ok = 1'b1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL wait_sel%0d timeout an=%b", n, an);
        end
    endtask

    task automatic wait_model_step(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (m_step == n) ok = 1'b1;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL wait_step%0d timeout step=%0d", n, m_step);
        end
    endtask

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog expired");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        int n;
        bit ok;
        model_reset();
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_ld", ld, 8'h00);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg_n, 7'b0000001);
        chk("rst_dp", dp, 1'b1);
        chk("rst_mem", mem_all, 5'b11111);
        @(posedge clk); #2 rst_n = 1'b1;

        press(1);
        wait_sel(3); chk("edit_glyph_E", seg_n, 7'b0110000);
        sw = 8'hA5; press(2); chk("edit_ld_a5", ld, 8'hA5);
        press(4); chk("edit_step1_ld", ld, 8'h00);
        press(3); press(3);
        wait_sel(0); chk("edit_digit7", seg_n, 7'b0001111);

        sw = 8'h18; press(2);
        press(4); sw = 8'h81; press(2);
        press(1);
        press(0);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (ld === 8'h18) ok = 1'b1;
        end
        chk("play_reach_step7", ok, 1'b1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ld !== 8'h18) break;
            n++;
        end
        chk("play_step_len", n, 4);
        chk("play_wrap_ld", ld, 8'h81);

        wait_model_step(1);
        wait_model_step(2);
        @(posedge clk); #2;
        btn[0] = 1'b1; repeat (4) step();
        btn[0] = 1'b0; repeat (20) step();
        chk("stop_model_step", m_step, 3);
        wait_sel(0); chk("stop_digit3", seg_n, 7'b0000110);
        wait_sel(3); chk("stop_glyph_5", seg_n, 7'b0100100);

        press(2);
        press(1);
        repeat (4) press(4);
        chk("cleared_step7", ld, 8'h00);

        btn[4] = 1'b1; step(); btn[4] = 1'b0;
        repeat (6) step();
        wait_sel(0); chk("glitch_digit7", seg_n, 7'b0001111);

        btn[1] = 1'b1; btn[3] = 1'b1;
        repeat (8) step();
        btn = 5'b0; repeat (4) step();
        wait_sel(3); chk("combo_glyph_5", seg_n, 7'b0100100);
        wait_sel(0); chk("combo_digit7", seg_n, 7'b0001111);

        press(1); press(3); press(3);
        sw = 8'hFF; press(2);
        chk("prog_step5", ld, 8'hFF);
        press(1); press(0);
        wait_model_step(4);
        wait_model_step(5);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("midrst_ld", ld, 8'h00);
        chk("midrst_an", an, 4'b1110);
        chk("midrst_seg", seg_n, 7'b0000001);
        repeat (2) step();
        rst_n = 1'b1;
        press(1); press(3); press(3); press(3);
        chk("midrst_pattern_lost", ld, 8'h00);
        press(1);

        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(5) == 0) btn[b] = ~btn[b];
            if ($urandom_range(15) == 0) sw = 8'($urandom);
            rst_n = ($urandom_range(1499) != 0);
            step();
        end
        rst_n = 1'b1;
        btn = 5'b0;
        repeat (4) step();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/drum_machine_top.md
Name: drum_machine_top

Overview:
Top level of an 8-step, 8-track drum-machine sequencer for the Nexys-class board. A controller FSM (STOP/PLAY/EDIT) steps through an 8x8 pattern memory. Switches define the hit pattern for each step and LEDs show the current step's hits. A multiplexed 4-digit 7-segment display shows mode and step, and the on-board memories are held disabled.

Parameters:
STEP_DIV, 12500000, clocks per sequencer step in PLAY (range 2 and up)
DB_CYCLES, 500000, consecutive stable-high clocks needed to accept a button press (range 1 and up)
SCAN_BITS, 18, width of the free-running display scan counter; digit select = cnt[SCAN_BITS-1:SCAN_BITS-2]

Ports:
ClkPort  in  1  system clock, rising edge
ResetN  in  1  asynchronous active-low reset
BtnC, BtnU, BtnD, BtnL, BtnR  in  1 each  push buttons, active-high, asynchronous to clock
Sw7..Sw0  in  1 each  hit pattern entry; Sw[i] = track i
Ld7..Ld0  out  1 each  Ld[i] = pattern[step][i]
An3..An0  out  1 each  digit anodes, active-low
Ca, Cb, Cc, Cd, Ce, Cf, Cg, Dp  out  1 each  segment cathodes, active-low
MemOE, MemWR, RamCS, FlashCS, QuadSpiFlashCS  out  1 each  constant 1 (memories disabled)

Behaviour:
- Reset (ResetN=0, async): state=STOP; step=0; all 8 pattern bytes=0; tick counter, scan counter and debounce counters=0. Resulting outputs: Ld=0, An0=0, An3..An1=1, cathodes show '0' (Ca-Cf=0, Cg=1), Dp=1.
- Button front end, each button: 2-FF synchronizer, then a counter of consecutive high samples. When the counter reaches DB_CYCLES, emit one 1-clock pulse. Re-arm only after the synced level is seen low. Any low sample clears the counter.
- Pulse priority in the same clock is BtnC > BtnU > BtnD > BtnL > BtnR. Only the highest-priority pulse acts; the others are dropped.
- STOP:
  - BtnC: go to PLAY and clear the tick counter.
  - BtnU: go to EDIT.
  - BtnD: clear all pattern bytes.
  - BtnL, BtnR: ignored.
- PLAY:
  - Tick counter increments each clock. At STEP_DIV-1 it wraps to 0 and step = (step+1) mod 8 (7 wraps to 0).
  - The first advance occurs STEP_DIV clocks after the entering pulse.
  - BtnC: go to STOP; step is retained.
  - BtnU: go to EDIT; step is retained.
  - Other buttons: ignored.
- EDIT:
  - Step acts as the edit cursor.
  - BtnL: step = (step-1) mod 8, so 0 wraps to 7.
  - BtnR: step = (step+1) mod 8.
  - BtnD: pattern[step] <= {Sw7..Sw0} sampled that clock.
  - BtnU: go to STOP.
  - BtnC: ignored.
- LEDs are combinational from pattern[step] in all states and update in the same clock the step or pattern changes.
- Display:
  - Scan select 0 -> An0 shows step digit '0'..'7'.
  - Select 1 -> An1 and select 2 -> An2 are blank (all cathodes 1, anode still driven low).
  - Select 3 -> An3 shows the mode letter: STOP='5' glyph (a,c,d,f,g), PLAY='P' (a,b,e,f,g), EDIT='E' (a,d,e,f,g).
  - Exactly one anode is low at any time. Dp is always 1.
  - Digit glyphs are standard: '0'=a-f, '1'=b,c, '2'=a,b,d,e,g, '3'=a,b,c,d,g, '4'=b,c,f,g, '5'=a,c,d,f,g, '6'=a,c,d,e,f,g, '7'=a,b,c.
- Reset asserted mid-PLAY or mid-EDIT returns immediately to the reset state; the pattern is lost.
- All outputs are glitch-free registered or combinational decode of registers. No latches.

Test Plan:
(Use STEP_DIV=4, DB_CYCLES=2, SCAN_BITS=4.)
- Reset: hold ResetN=0 for 5 clocks -> Ld=0x00, An0=0, others 1, Ca-Cf=0, Cg=1, Dp=1, all Mem*/CS outputs 1.
- Edit entry: press BtnU (held 4 clocks, then released) -> EDIT and An3 glyph 'E'. Set Sw=0xA5 and pulse BtnD -> Ld=0xA5. Pulse BtnR -> step 1, Ld=0x00. Pulse BtnL twice -> step 7.
- Play wrap: program step0=0x81 and step7=0x18, exit to STOP, pulse BtnC -> PLAY. Step advances every 4 clocks 0->1->...->7->0; Ld=0x18 at step 7 and 0x81 at step 0.
- Stop/retain and clear: pulse BtnC during PLAY at step 3 -> STOP, step stays 3 across 20 clocks. Pulse BtnD -> all patterns 0.
- Button timing: a 1-clock glitch on BtnR produces no action. Holding BtnU and BtnL high together produces only the BtnU action, once.
- Reset mid-operation: drop ResetN during PLAY at step 5 -> immediately STOP, step 0, Ld=0x00, pattern cleared.
